// File: rtl/nanorisc_trace_pkg.sv
// nanorisc_trace_pkg: shared state encodings and entry-width helper for the trace buffer
package nanorisc_trace_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_READ = 2'd3} state_t;
  // Entry layout, MSB to LSB: {stamp, pc, instr, ctrl}
  function automatic int entry_w(input int s, input int a, input int i, input int c);
    return s + a + i + c;
  endfunction
endpackage

// File: rtl/nanorisc_trace_ram.sv
// nanorisc_trace_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port
module nanorisc_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 40
) (
  input  logic                     i_clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/nanorisc_trace_buffer.sv
// nanorisc_trace_buffer: triggered circular execution tracer with oldest-first valid/ready replay
module nanorisc_trace_buffer
  import nanorisc_trace_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 8,
  parameter int CTRL_W     = 8,
  parameter int STAMP_W    = 16,
  parameter int DEPTH      = 16,
  parameter int POST_COUNT = 8
) (
  input  logic                                        i_clock,
  input  logic                                        i_reset,
  input  logic                                        i_sample_en,
  input  logic [ADDR_W-1:0]                           i_pc,
  input  logic [INSTR_W-1:0]                          i_instr,
  input  logic [CTRL_W-1:0]                           i_ctrl,
  input  logic                                        i_arm,
  input  logic                                        i_abort,
  input  logic                                        i_trig_en,
  input  logic [ADDR_W-1:0]                           i_trig_pc,
  input  logic                                        i_force_trig,
  output logic                                        o_rd_valid,
  input  logic                                        i_rd_ready,
  output logic [STAMP_W+ADDR_W+INSTR_W+CTRL_W-1:0]    o_rd_data,
  output logic                                        o_rd_last,
  output logic [1:0]                                  o_state,
  output logic [STAMP_W-1:0]                          o_cycle_count
);
  localparam int E  = entry_w(STAMP_W, ADDR_W, INSTR_W, CTRL_W);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  state_t r_state, w_next;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FW-1:0] r_fill, r_rem, r_post;
  logic r_rd_valid;
  logic [STAMP_W-1:0] r_cycle;
  logic [E-1:0] w_rdata;
  logic w_we, w_trig, w_xfer;
  assign w_we   = (r_state == S_ARMED || r_state == S_POST) && i_sample_en && !i_abort;
  assign w_trig = r_state == S_ARMED && i_sample_en && ((i_trig_en && i_pc == i_trig_pc) || i_force_trig);
  assign w_xfer = r_rd_valid && i_rd_ready;
  nanorisc_trace_ram #(.DEPTH(DEPTH), .W(E)) u_ram (
    .i_clock (i_clock),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({r_cycle, i_pc, i_instr, i_ctrl}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_arm ? S_ARMED : S_IDLE;
      S_ARMED: w_next = w_trig ? (POST_COUNT == 0 ? S_READ : S_POST) : S_ARMED;
      S_POST:  w_next = (i_sample_en && r_post == FW'(1)) ? S_READ : S_POST;
      S_READ:  w_next = (w_xfer && r_rem == FW'(1)) ? S_IDLE : S_READ;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end
  always_ff @(posedge i_clock)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_rem      <= '0;
      r_post     <= '0;
      r_rd_valid <= 1'b0;
      r_cycle    <= '0;
    end else begin
      r_cycle <= r_cycle + STAMP_W'(1);
      if (r_state == S_IDLE && i_arm && !i_abort) r_fill <= '0;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_fill   <= (r_fill == FW'(DEPTH)) ? r_fill : r_fill + FW'(1);
      end
      if (w_trig) r_post <= FW'(POST_COUNT);
      else if (w_we && r_state == S_POST) r_post <= r_post - FW'(1);
      // Window start is loaded one cycle after entering READ, once the final store has landed
      if (i_abort) begin
        r_rd_valid <= 1'b0;
        r_rem      <= '0;
      end else if (r_state == S_READ && !r_rd_valid) begin
        r_rd_ptr   <= r_wr_ptr - r_fill[AW-1:0];
        r_rem      <= r_fill;
        r_rd_valid <= 1'b1;
      end else if (w_xfer) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_rem      <= r_rem - FW'(1);
        r_rd_valid <= r_rem != FW'(1);
      end
    end
  end
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_valid ? w_rdata : '0;
  assign o_rd_last     = r_rd_valid && r_rem == FW'(1);
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle;
endmodule

// File: tb/tb_nanorisc_trace_buffer.sv
// tb_nanorisc_trace_buffer: directed checks of capture, trigger, wrap, stall, abort and reset
module tb_nanorisc_trace_buffer;
  logic clk = 0, rst = 1, sample_en = 0, arm = 0, arm0 = 0, abort = 0;
  logic trig_en = 0, force_trig = 0, rd_ready = 0, sel = 0;
  logic [7:0] pc = 0, instr = 0, ctrl = 0, trig_pc = 0;
  logic v1, l1, v0, l0;
  logic [39:0] d1, d0;
  logic [1:0] st1, st0;
  logic [15:0] cc1, cc0, tb_cyc;
  logic [15:0] stamp [64];
  int errs = 0, checks = 0;
  logic rv, rl;
  logic [39:0] rd;
  logic [1:0] rs;
  assign rv = sel ? v0 : v1;
  assign rl = sel ? l0 : l1;
  assign rd = sel ? d0 : d1;
  assign rs = sel ? st0 : st1;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= rst ? 16'd0 : tb_cyc + 16'd1;

  nanorisc_trace_buffer u_dut (
    .i_clock(clk), .i_reset(rst), .i_sample_en(sample_en), .i_pc(pc), .i_instr(instr),
    .i_ctrl(ctrl), .i_arm(arm), .i_abort(abort), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_force_trig(force_trig), .o_rd_valid(v1), .i_rd_ready(rd_ready), .o_rd_data(d1),
    .o_rd_last(l1), .o_state(st1), .o_cycle_count(cc1)
  );
  nanorisc_trace_buffer #(.POST_COUNT(0)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_sample_en(sample_en), .i_pc(pc), .i_instr(instr),
    .i_ctrl(ctrl), .i_arm(arm0), .i_abort(abort), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_force_trig(force_trig), .o_rd_valid(v0), .i_rd_ready(rd_ready), .o_rd_data(d0),
    .o_rd_last(l0), .o_state(st0), .o_cycle_count(cc0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int p);
    pc = p[7:0];
    instr = pc ^ 8'h5A;
    ctrl = ~pc;
    sample_en = 1;
    stamp[p] = tb_cyc;
    step();
  endtask

  function automatic logic [39:0] ent(input int p);
    logic [7:0] b;
    b = p[7:0];
    return {stamp[p], b, b ^ 8'h5A, ~b};
  endfunction

  task automatic read_win(input int first, input int n, input int stall_at);
    logic [39:0] held;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        held = rd;
        rd_ready = 0;
        for (int k = 0; k < 5; k++) begin
          step();
          chk("stall valid", rv, 1);
          chk("stall data", rd, held);
        end
      end
      chk("rd_valid", rv, 1);
      chk("rd_data", rd, ent(first + i));
      chk("rd_last", rl, i == n - 1);
      rd_ready = 1;
      step();
      rd_ready = 0;
    end
    chk("idle after read", rs, 0);
    chk("valid drop", rv, 0);
  endtask

  initial begin
    step();
    step();
    rst = 0;
    chk("rst state", st1, 0);
    chk("rst valid", v1, 0);
    chk("rst last", l1, 0);
    chk("rst data", d1, 0);
    chk("rst cycle", cc1, 0);
    chk("rst state0", st0, 0);
    // Capture 10 samples: trigger at pc=1, 8 post samples
    arm = 1;
    step();
    arm = 0;
    chk("armed", st1, 1);
    chk("cycle count", cc1, tb_cyc);
    trig_en = 1;
    trig_pc = 8'd1;
    for (int p = 0; p < 10; p++) begin
      smp(p);
      if (p == 1) chk("post entered", st1, 2);
    end
    sample_en = 0;
    chk("read entered", st1, 3);
    chk("valid latency", v1, 0);
    step();
    read_win(0, 10, -1);
    // Wrap: 40 samples, trigger at pc=30, window pc 23..38, with a stall
    arm = 1;
    step();
    arm = 0;
    trig_pc = 8'd30;
    for (int p = 0; p < 39; p++) smp(p);
    chk("wrap read", st1, 3);
    chk("wrap valid latency", v1, 0);
    smp(39);
    sample_en = 0;
    read_win(23, 16, 4);
    // POST_COUNT=0 build
    sel = 1;
    arm0 = 1;
    step();
    arm0 = 0;
    trig_pc = 8'd7;
    for (int p = 0; p < 8; p++) smp(p);
    sample_en = 0;
    chk("pc0 read", st0, 3);
    chk("pc0 valid latency", v0, 0);
    step();
    read_win(0, 8, -1);
    sel = 0;
    // Abort in POST
    arm = 1;
    step();
    arm = 0;
    trig_pc = 8'd2;
    for (int p = 0; p < 3; p++) smp(p);
    chk("abort post state", st1, 2);
    abort = 1;
    smp(3);
    abort = 0;
    chk("abort idle", st1, 0);
    for (int p = 4; p < 16; p++) begin
      smp(p);
      chk("abort no valid", v1, 0);
    end
    // Trigger and abort in the same cycle
    arm = 1;
    sample_en = 0;
    step();
    arm = 0;
    smp(0);
    abort = 1;
    smp(2);
    abort = 0;
    chk("trig abort idle", st1, 0);
    for (int p = 3; p < 13; p++) begin
      smp(p);
      chk("trig abort no valid", v1, 0);
    end
    sample_en = 0;
    // Forced trigger, then reset during READ
    arm = 1;
    trig_en = 0;
    step();
    arm = 0;
    force_trig = 1;
    step();
    chk("force waits", st1, 1);
    smp(0);
    force_trig = 0;
    chk("force post", st1, 2);
    for (int p = 1; p < 9; p++) smp(p);
    sample_en = 0;
    step();
    chk("force valid", v1, 1);
    chk("force first", d1, ent(0));
    rst = 1;
    step();
    chk("mid rst state", st1, 0);
    chk("mid rst valid", v1, 0);
    chk("mid rst last", l1, 0);
    chk("mid rst data", d1, 0);
    chk("mid rst cycle", cc1, 0);
    rst = 0;
    step();
    chk("cycle restart", cc1, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
